ctrl_pipe_unit: RTL and testbench

Registered, condition-aware decode/control stage for the ARM datapath, sitting between instruction decode and the ID/EXE pipeline register. It generalises the combinational control decode:
- command width is parametrised
- ARM condition-code evaluation against NZCV
- hazard-stall and branch-flush bubble insertion
- a multi-cycle MUL sequencer that back-pressures upstream via busy

---
 rtl/ctrl_pipe_if.sv | 34 +++
 rtl/ctrl_pipe_unit.sv | 202 ++++++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// Decode-to-control bundle for ctrl_pipe_unit: decoded instruction fields and status flags in,
// registered control word and busy back-pressure out.
interface ctrl_pipe_if #(
    parameter int OPCODE_W  = 4,
    parameter int EXE_CMD_W = 4
);
    logic                 instValid;
    logic [1:0]           mode;
    logic [OPCODE_W-1:0]  opCode;
    logic                 sIn;
    logic [3:0]           cond;
    logic [3:0]           statusNZCV;
    logic                 hazard;
    logic                 flush;
    logic                 ctrlValid;
    logic [EXE_CMD_W-1:0] exeCmd;
    logic                 memReadEn;
    logic                 memWriteEn;
    logic                 writeBackEn;
    logic                 b;
    logic                 sOut;
    logic                 busy;
    logic                 illegal;

    modport master (
        output instValid, mode, opCode, sIn, cond, statusNZCV, hazard, flush,
        input  ctrlValid, exeCmd, memReadEn, memWriteEn, writeBackEn, b, sOut, busy, illegal
    );

    modport slave (
        input  instValid, mode, opCode, sIn, cond, statusNZCV, hazard, flush,
        output ctrlValid, exeCmd, memReadEn, memWriteEn, writeBackEn, b, sOut, busy, illegal
    );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// Registered ARM decode/control stage: condition evaluation, stall/flush bubbles and an optional
// multi-cycle MUL sequencer enabled by defining CTRL_MUL_EN (otherwise mode 11 is illegal).
module ctrl_pipe_unit #(
    parameter int EXE_CMD_W  = 4,
    parameter int OPCODE_W   = 4,
    parameter int MUL_CYCLES = 4
) (
    input logic         clk,
    input logic         rst,
    ctrl_pipe_if.slave  bus
);
    function automatic logic f_cond_pass(input logic [3:0] c, input logic [3:0] nzcv);
        logic n, z, cf, v;
        logic pass;
        {n, z, cf, v} = nzcv;
        case (c)
            4'b0000: pass = z;
            4'b0001: pass = !z;
            4'b0010: pass = cf;
            4'b0011: pass = !cf;
            4'b0100: pass = n;
            4'b0101: pass = !n;
            4'b0110: pass = v;
            4'b0111: pass = !v;
            4'b1000: pass = cf & !z;
            4'b1001: pass = !cf | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = !z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    logic       w_opHi;
    logic [3:0] w_cmd;
    logic       w_mr, w_mw, w_wb, w_b, w_s, w_ill, w_isMul;
    logic       w_take;

    assign w_opHi = ((bus.opCode >> 4) != '0);
    // An instruction is taken only when nothing stalls or kills it and its condition passes.
    assign w_take = !bus.flush && !bus.hazard && bus.instValid &&
                    f_cond_pass(bus.cond, bus.statusNZCV);

    always_comb begin
        w_cmd   = 4'b0000;
        w_mr    = 1'b0;
        w_mw    = 1'b0;
        w_wb    = 1'b0;
        w_b     = 1'b0;
        w_s     = 1'b0;
        w_ill   = 1'b0;
        w_isMul = 1'b0;
        case (bus.mode)
            2'b00: begin
                w_wb = 1'b1;
                w_s  = bus.sIn;
                if (w_opHi) begin
                    w_ill = 1'b1;
                end else begin
                    case (bus.opCode[3:0])
                        4'b1101: w_cmd = 4'b0001;
                        4'b1111: w_cmd = 4'b1001;
                        4'b0100: w_cmd = 4'b0010;
                        4'b0101: w_cmd = 4'b0011;
                        4'b0010: w_cmd = 4'b0100;
                        4'b0110: w_cmd = 4'b0101;
                        4'b0000: w_cmd = 4'b0110;
                        4'b1100: w_cmd = 4'b0111;
                        4'b0001: w_cmd = 4'b1000;
                        4'b1010: begin w_cmd = 4'b0100; w_wb = 1'b0; w_s = 1'b1; end
                        4'b1000: begin w_cmd = 4'b0110; w_wb = 1'b0; w_s = 1'b1; end
                        default: w_ill = 1'b1;
                    endcase
                end
            end
            2'b01: begin
                w_cmd = 4'b0010;
                w_mr  = bus.sIn;
                w_wb  = bus.sIn;
                w_mw  = !bus.sIn;
            end
            2'b10: w_b = 1'b1;
            default: begin
`ifdef CTRL_MUL_EN
                w_isMul = 1'b1;
                w_cmd   = 4'b1010;
                w_wb    = 1'b1;
                w_s     = bus.sIn;
`else
                w_ill   = 1'b1;
`endif
            end
        endcase
    end

    logic                 r_ctrlValid;
    logic [EXE_CMD_W-1:0] r_exeCmd;
    logic                 r_memReadEn, r_memWriteEn, r_writeBackEn, r_b, r_sOut, r_illegal;

`ifdef CTRL_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
    typedef enum logic {IDLE, MUL_BUSY} state_t;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_mulS;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrlValid   <= 1'b0;
            r_exeCmd      <= '0;
            r_memReadEn   <= 1'b0;
            r_memWriteEn  <= 1'b0;
            r_writeBackEn <= 1'b0;
            r_b           <= 1'b0;
            r_sOut        <= 1'b0;
            r_illegal     <= 1'b0;
`ifdef CTRL_MUL_EN
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_mulS        <= 1'b0;
`endif
        end else begin
            r_ctrlValid   <= 1'b0;
            r_exeCmd      <= '0;
            r_memReadEn   <= 1'b0;
            r_memWriteEn  <= 1'b0;
            r_writeBackEn <= 1'b0;
            r_b           <= 1'b0;
            r_sOut        <= 1'b0;
            r_illegal     <= 1'b0;
`ifdef CTRL_MUL_EN
            case (r_state)
                IDLE: begin
                    r_illegal <= w_take && w_ill;
                    if (w_take && !w_ill && w_isMul) begin
                        r_state <= MUL_BUSY;
                        r_cnt   <= CNT_W'(MUL_CYCLES - 2);
                        r_busy  <= 1'b1;
                        r_mulS  <= bus.sIn;
                    end else if (w_take && !w_ill) begin
                        r_ctrlValid   <= 1'b1;
                        r_exeCmd      <= EXE_CMD_W'(w_cmd);
                        r_memReadEn   <= w_mr;
                        r_memWriteEn  <= w_mw;
                        r_writeBackEn <= w_wb;
                        r_b           <= w_b;
                        r_sOut        <= w_s;
                    end
                end
                default: begin
                    // flush outranks completion, so a killed MUL is never issued.
                    if (bus.flush) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!bus.hazard) begin
                        r_ctrlValid   <= 1'b1;
                        r_exeCmd      <= EXE_CMD_W'(4'b1010);
                        r_writeBackEn <= 1'b1;
                        r_sOut        <= r_mulS;
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                    end
                end
            endcase
`else
            r_illegal <= w_take && w_ill;
            if (w_take && !w_ill) begin
                r_ctrlValid   <= 1'b1;
                r_exeCmd      <= EXE_CMD_W'(w_cmd);
                r_memReadEn   <= w_mr;
                r_memWriteEn  <= w_mw;
                r_writeBackEn <= w_wb;
                r_b           <= w_b;
                r_sOut        <= w_s;
            end
`endif
        end
    end

    assign bus.ctrlValid   = r_ctrlValid;
    assign bus.exeCmd      = r_exeCmd;
    assign bus.memReadEn   = r_memReadEn;
    assign bus.memWriteEn  = r_memWriteEn;
    assign bus.writeBackEn = r_writeBackEn;
    assign bus.b           = r_b;
    assign bus.sOut        = r_sOut;
    assign bus.illegal     = r_illegal;
`ifdef CTRL_MUL_EN
    assign bus.busy        = r_busy;
`else
    assign bus.busy        = 1'b0;
`endif
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit; outputs packed as
// {ctrlValid, exeCmd[3:0], memReadEn, memWriteEn, writeBackEn, b, sOut, busy, illegal}.
module tb_ctrl_pipe_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    ctrl_pipe_if #(.OPCODE_W(4), .EXE_CMD_W(4)) bus ();

    ctrl_pipe_unit #(.EXE_CMD_W(4), .OPCODE_W(4), .MUL_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [11:0] obs;
    assign obs = {bus.ctrlValid, bus.exeCmd, bus.memReadEn, bus.memWriteEn,
                  bus.writeBackEn, bus.b, bus.sOut, bus.busy, bus.illegal};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic v, input logic [1:0] m, input logic [3:0] op,
                            input logic s, input logic [3:0] c);
        bus.instValid = v;
        bus.mode      = m;
        bus.opCode    = op;
        bus.sIn       = s;
        bus.cond      = c;
    endtask

    task automatic test_reset();
        set_inst(1'b1, 2'b00, 4'b0100, 1'b1, 4'b1110);
        #2 rst = 1'b1;
        step();
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL reset_outputs got=%h exp=%h", obs, 12'h000); n_fail++;
        end
        @(negedge clk) rst = 1'b1;
        step();
        n_chk++;
        if (obs !== 12'h914) begin
            $display("FAIL reset_first_add got=%h exp=%h", obs, 12'h914); n_fail++;
        end
    endtask

    task automatic test_cond();
        set_inst(1'b1, 2'b00, 4'b0100, 1'b0, 4'b0000);
        bus.statusNZCV = 4'b0000;
        step();
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL cond_eq_fail got=%h exp=%h", obs, 12'h000); n_fail++;
        end
        bus.statusNZCV = 4'b0100;
        step();
        n_chk++;
        if (obs !== 12'h910) begin
            $display("FAIL cond_eq_pass got=%h exp=%h", obs, 12'h910); n_fail++;
        end
        bus.cond = 4'b1011; bus.statusNZCV = 4'b1000;
        step();
        n_chk++;
        if (obs !== 12'h910) begin
            $display("FAIL cond_lt_pass got=%h exp=%h", obs, 12'h910); n_fail++;
        end
        bus.cond = 4'b1100;
        step();
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL cond_gt_fail got=%h exp=%h", obs, 12'h000); n_fail++;
        end
        bus.cond = 4'b1111; bus.statusNZCV = 4'b0000;
        step();
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL cond_nv got=%h exp=%h", obs, 12'h000); n_fail++;
        end
    endtask

    task automatic test_hazard();
        set_inst(1'b1, 2'b01, 4'b0000, 1'b1, 4'b1110);
        bus.hazard = 1'b1;
        step();
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL hazard_bubble got=%h exp=%h", obs, 12'h000); n_fail++;
        end
        bus.hazard = 1'b0;
        step();
        n_chk++;
        if (obs !== 12'h950) begin
            $display("FAIL hazard_ldr got=%h exp=%h", obs, 12'h950); n_fail++;
        end
        bus.sIn = 1'b0;
        step();
        n_chk++;
        if (obs !== 12'h920) begin
            $display("FAIL str got=%h exp=%h", obs, 12'h920); n_fail++;
        end
    endtask

    task automatic test_decode();
        set_inst(1'b1, 2'b00, 4'b1010, 1'b0, 4'b1110);
        step();
        n_chk++;
        if (obs !== 12'hA04) begin
            $display("FAIL dec_cmp got=%h exp=%h", obs, 12'hA04); n_fail++;
        end
        set_inst(1'b1, 2'b00, 4'b1101, 1'b0, 4'b1110);
        step();
        n_chk++;
        if (obs !== 12'h890) begin
            $display("FAIL dec_mov got=%h exp=%h", obs, 12'h890); n_fail++;
        end
        set_inst(1'b1, 2'b00, 4'b1111, 1'b1, 4'b1110);
        step();
        n_chk++;
        if (obs !== 12'hC94) begin
            $display("FAIL dec_mvn got=%h exp=%h", obs, 12'hC94); n_fail++;
        end
        set_inst(1'b1, 2'b10, 4'b0000, 1'b0, 4'b1110);
        step();
        n_chk++;
        if (obs !== 12'h808) begin
            $display("FAIL dec_branch got=%h exp=%h", obs, 12'h808); n_fail++;
        end
        set_inst(1'b0, 2'b00, 4'b0100, 1'b0, 4'b1110);
        step();
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL dec_invalid got=%h exp=%h", obs, 12'h000); n_fail++;
        end
    endtask

    task automatic test_flush();
        set_inst(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1110);
        bus.flush = 1'b1;
        step();
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL flush_add got=%h exp=%h", obs, 12'h000); n_fail++;
        end
        bus.flush = 1'b0;
    endtask

    task automatic test_illegal();
        set_inst(1'b1, 2'b00, 4'b0011, 1'b0, 4'b1110);
        step();
        n_chk++;
        if (obs !== 12'h001) begin
            $display("FAIL illegal_pulse got=%h exp=%h", obs, 12'h001); n_fail++;
        end
        bus.instValid = 1'b0;
        step();
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL illegal_one_cycle got=%h exp=%h", obs, 12'h000); n_fail++;
        end
    endtask

`ifdef CTRL_MUL_EN
    task automatic test_mul();
        set_inst(1'b1, 2'b11, 4'b0000, 1'b0, 4'b1110);
        step();
        set_inst(1'b1, 2'b00, 4'b0100, 1'b1, 4'b1110);
        for (int i = 1; i <= 3; i++) begin
            n_chk++;
            if (obs !== 12'h002) begin
                $display("FAIL mul_busy_c%0d got=%h exp=%h", i, obs, 12'h002); n_fail++;
            end
            step();
        end
        n_chk++;
        if (obs !== 12'hD10) begin
            $display("FAIL mul_issue got=%h exp=%h", obs, 12'hD10); n_fail++;
        end
        bus.instValid = 1'b0;
        step();
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL mul_after got=%h exp=%h", obs, 12'h000); n_fail++;
        end
    endtask

    task automatic test_mul_hazard();
        set_inst(1'b1, 2'b11, 4'b0000, 1'b0, 4'b1110);
        step();
        bus.instValid = 1'b0;
        step();
        step();
        bus.hazard = 1'b1;
        step();
        step();
        n_chk++;
        if (obs !== 12'h002) begin
            $display("FAIL mul_hazard_hold got=%h exp=%h", obs, 12'h002); n_fail++;
        end
        bus.hazard = 1'b0;
        step();
        n_chk++;
        if (obs !== 12'hD10) begin
            $display("FAIL mul_hazard_issue got=%h exp=%h", obs, 12'hD10); n_fail++;
        end
    endtask

    task automatic test_mul_flush();
        set_inst(1'b1, 2'b11, 4'b0000, 1'b0, 4'b1110);
        step();
        bus.instValid = 1'b0;
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        for (int i = 3; i <= 7; i++) begin
            n_chk++;
            if (obs !== 12'h000) begin
                $display("FAIL mul_flush_c%0d got=%h exp=%h", i, obs, 12'h000); n_fail++;
            end
            step();
        end
        set_inst(1'b1, 2'b11, 4'b0000, 1'b0, 4'b1110);
        step();
        bus.instValid = 1'b0;
        step();
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL mul_flush_at_done got=%h exp=%h", obs, 12'h000); n_fail++;
        end
        set_inst(1'b1, 2'b11, 4'b0000, 1'b0, 4'b1110);
        step();
        bus.instValid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL mul_reset got=%h exp=%h", obs, 12'h000); n_fail++;
        end
        @(negedge clk) rst = 1'b1;
        step();
    endtask
`else
    task automatic test_no_mul();
        set_inst(1'b1, 2'b11, 4'b0000, 1'b0, 4'b1110);
        step();
        n_chk++;
        if (obs !== 12'h001) begin
            $display("FAIL nomul_illegal got=%h exp=%h", obs, 12'h001); n_fail++;
        end
        bus.instValid = 1'b0;
        step();
        n_chk++;
        if (obs !== 12'h000) begin
            $display("FAIL nomul_after got=%h exp=%h", obs, 12'h000); n_fail++;
        end
    endtask
`endif

    initial begin
        set_inst(1'b0, 2'b00, 4'b0000, 1'b0, 4'b1110);
        bus.statusNZCV = 4'b0000;
        bus.hazard     = 1'b0;
        bus.flush      = 1'b0;
        test_reset();
        test_cond();
        test_hazard();
        test_decode();
        test_flush();
        test_illegal();
`ifdef CTRL_MUL_EN
        test_mul();
        test_mul_hazard();
        test_mul_flush();
`else
        test_no_mul();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
